// File: rtl/im2col_router.sv
// im2col beat generator: walks taps x output-pixel batches, fetching elements from a packed-word SRAM with word reuse.
// Latency: 1 cycle per hit/invalid/padded lane, read latency + 1 per miss; a beat holds in EMIT until i_data_ready.
// Optional zero padding (i_pad port and bounds check) enabled by defining IM2COL_ROUTER_PAD_EN.
module im2col_router #(
  parameter int ROW_COUNT   = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int WORD_ELEMS  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int DIM_WIDTH   = 8,
  parameter int KERNEL_SIZE = 3
) (
  input  logic                                 i_clk,
  input  logic                                 i_nrst,
  input  logic                                 i_reg_clear,
  input  logic                                 i_start,
  input  logic [ADDR_WIDTH-1:0]                i_start_addr,
  input  logic [DIM_WIDTH-1:0]                 i_i_size,
  input  logic [DIM_WIDTH-1:0]                 i_o_size,
  input  logic [DIM_WIDTH-1:0]                 i_stride,
`ifdef IM2COL_ROUTER_PAD_EN
  input  logic [DIM_WIDTH-1:0]                 i_pad,
`endif
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_sram_read_en,
  output logic [ADDR_WIDTH-1:0]                o_sram_read_addr,
  input  logic [DATA_WIDTH*WORD_ELEMS-1:0]     i_sram_data,
  input  logic                                 i_sram_data_valid,
  output logic [ROW_COUNT-1:0][DATA_WIDTH-1:0] o_data,
  output logic [ROW_COUNT-1:0]                 o_row_valid,
  output logic                                 o_data_valid,
  input  logic                                 i_data_ready
);
  localparam int PW  = 2 * DIM_WIDTH;
  localparam int SW  = PW + 2;
  localparam int WSH = $clog2(WORD_ELEMS);
  localparam int LW  = (ROW_COUNT > 1) ? $clog2(ROW_COUNT) : 1;
  localparam int KW  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam logic [LW-1:0] LANE_LAST = LW'(ROW_COUNT - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(KERNEL_SIZE - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} state_t;
  state_t state;

  logic [ADDR_WIDTH-1:0]            cfg_start_addr;
  logic [DIM_WIDTH-1:0]             cfg_i_size, cfg_o_size, cfg_stride, pad_val;
  logic [LW-1:0]                    lane;
  logic [KW-1:0]                    kx, ky;
  logic [DIM_WIDTH-1:0]             cur_oy, cur_ox, base_oy, base_ox;
  logic [PW-1:0]                    cur_p, base_p;
  logic [DATA_WIDTH*WORD_ELEMS-1:0] word_reg;
  logic [ADDR_WIDTH-1:0]            word_addr;
  logic                             word_vld;

  logic [PW-1:0]            n_pix, oy_m, ox_m, e;
  logic signed [SW-1:0]     iy_s, ix_s;
  logic [ADDR_WIDTH-1:0]    rd_addr;
  logic [WSH-1:0]           sel;
  logic                     lane_in, pad_zero, hit, adv;
  logic [DATA_WIDTH-1:0]    cap_val;

`ifdef IM2COL_ROUTER_PAD_EN
  logic [DIM_WIDTH-1:0] cfg_pad;
  logic signed [SW-1:0] isz_s;
  assign pad_val  = cfg_pad;
  assign isz_s    = $signed({{(SW-DIM_WIDTH){1'b0}}, cfg_i_size});
  assign pad_zero = iy_s[SW-1] || ix_s[SW-1] || (iy_s >= isz_s) || (ix_s >= isz_s);
`else
  assign pad_val  = '0;
  assign pad_zero = 1'b0;
`endif

  always_comb begin
    n_pix   = {{DIM_WIDTH{1'b0}}, cfg_o_size} * {{DIM_WIDTH{1'b0}}, cfg_o_size};
    oy_m    = {{DIM_WIDTH{1'b0}}, cur_oy} * {{DIM_WIDTH{1'b0}}, cfg_stride};
    ox_m    = {{DIM_WIDTH{1'b0}}, cur_ox} * {{DIM_WIDTH{1'b0}}, cfg_stride};
    iy_s    = $signed({2'b00, oy_m}) + $signed({{(SW-KW){1'b0}}, ky})
            - $signed({{(SW-DIM_WIDTH){1'b0}}, pad_val});
    ix_s    = $signed({2'b00, ox_m}) + $signed({{(SW-KW){1'b0}}, kx})
            - $signed({{(SW-DIM_WIDTH){1'b0}}, pad_val});
    e       = PW'(iy_s) * {{DIM_WIDTH{1'b0}}, cfg_i_size} + PW'(ix_s);
    rd_addr = cfg_start_addr + ADDR_WIDTH'(e >> WSH);
    sel     = e[WSH-1:0];
    lane_in = cur_p < n_pix;
    hit     = word_vld && (word_addr == rd_addr);
    // A lane completes this cycle if it needs no read, or its read data just arrived.
    adv     = ((state == FETCH) && (!lane_in || pad_zero || hit))
           || ((state == WAIT) && i_sram_data_valid);
    cap_val = '0;
    if (state == WAIT)
      cap_val = i_sram_data[DATA_WIDTH*int'(sel) +: DATA_WIDTH];
    else if (lane_in && !pad_zero)
      cap_val = word_reg[DATA_WIDTH*int'(sel) +: DATA_WIDTH];
  end

  task automatic clear_all();
    state            <= IDLE;
    cfg_start_addr   <= '0;
    cfg_i_size       <= '0;
    cfg_o_size       <= '0;
    cfg_stride       <= '0;
`ifdef IM2COL_ROUTER_PAD_EN
    cfg_pad          <= '0;
`endif
    lane             <= '0;
    kx               <= '0;
    ky               <= '0;
    cur_oy           <= '0;
    cur_ox           <= '0;
    cur_p            <= '0;
    base_oy          <= '0;
    base_ox          <= '0;
    base_p           <= '0;
    word_reg         <= '0;
    word_addr        <= '0;
    word_vld         <= 1'b0;
    o_busy           <= 1'b0;
    o_done           <= 1'b0;
    o_sram_read_en   <= 1'b0;
    o_sram_read_addr <= '0;
    o_data           <= '0;
    o_row_valid      <= '0;
    o_data_valid     <= 1'b0;
  endtask

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      clear_all();
    end else if (i_reg_clear) begin
      clear_all();
    end else begin
      o_done         <= 1'b0;
      o_sram_read_en <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          cfg_start_addr <= i_start_addr;
          cfg_i_size     <= i_i_size;
          cfg_o_size     <= i_o_size;
          cfg_stride     <= i_stride;
`ifdef IM2COL_ROUTER_PAD_EN
          cfg_pad        <= i_pad;
`endif
          word_vld <= 1'b0;
          lane     <= '0;
          kx       <= '0;
          ky       <= '0;
          cur_oy   <= '0;
          cur_ox   <= '0;
          cur_p    <= '0;
          base_oy  <= '0;
          base_ox  <= '0;
          base_p   <= '0;
          o_busy   <= 1'b1;
          state    <= (i_o_size == '0) ? DONE : FETCH;
        end
        FETCH, WAIT: begin
          if (adv) begin
            o_data[lane]      <= cap_val;
            o_row_valid[lane] <= lane_in;
            if (state == WAIT) begin
              word_reg  <= i_sram_data;
              word_addr <= rd_addr;
              word_vld  <= 1'b1;
            end
            // Coordinates advance even for invalid lanes so the batch end lands on base + ROW_COUNT.
            cur_p <= cur_p + 1'b1;
            if (cur_ox == cfg_o_size - DIM_WIDTH'(1)) begin
              cur_ox <= '0;
              cur_oy <= cur_oy + 1'b1;
            end else begin
              cur_ox <= cur_ox + 1'b1;
            end
            if (lane == LANE_LAST) begin
              state        <= EMIT;
              o_data_valid <= 1'b1;
            end else begin
              lane  <= lane + 1'b1;
              state <= FETCH;
            end
          end else if (state == FETCH) begin
            o_sram_read_en   <= 1'b1;
            o_sram_read_addr <= rd_addr;
            state            <= WAIT;
          end
        end
        EMIT: if (i_data_ready) begin
          o_data_valid <= 1'b0;
          lane         <= '0;
          if (kx != K_LAST) begin
            kx <= kx + 1'b1;
          end else begin
            kx <= '0;
            ky <= (ky == K_LAST) ? '0 : ky + 1'b1;
          end
          if (!(kx == K_LAST && ky == K_LAST)) begin
            cur_oy <= base_oy;
            cur_ox <= base_ox;
            cur_p  <= base_p;
            state  <= FETCH;
          end else if (cur_p >= n_pix) begin
            state <= DONE;
          end else begin
            base_oy <= cur_oy;
            base_ox <= cur_ox;
            base_p  <= cur_p;
            state   <= FETCH;
          end
        end
        DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_im2col_router.sv
// Bench for im2col_router: directed jobs, scoreboard of expected beats checked by a separate monitor.
`timescale 1ns/1ps
module tb_im2col_router;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  start_addr = 8'd0;
  logic [7:0]  i_size = 8'd0, o_size = 8'd0, stride = 8'd1;
`ifdef IM2COL_ROUTER_PAD_EN
  logic [7:0]  pad = 8'd0;
`endif
  logic        busy, done, rd_en;
  logic [7:0]  rd_addr;
  logic [63:0] sram_dat = '0;
  logic        sram_vld = 1'b0;
  logic [3:0][7:0] odata;
  logic [3:0]  row_vld;
  logic        dvld;
  logic        ready = 1'b1;

  im2col_router dut (
    .i_clk(clk), .i_nrst(nrst), .i_reg_clear(clr), .i_start(start),
    .i_start_addr(start_addr), .i_i_size(i_size), .i_o_size(o_size), .i_stride(stride),
`ifdef IM2COL_ROUTER_PAD_EN
    .i_pad(pad),
`endif
    .o_busy(busy), .o_done(done), .o_sram_read_en(rd_en), .o_sram_read_addr(rd_addr),
    .i_sram_data(sram_dat), .i_sram_data_valid(sram_vld),
    .o_data(odata), .o_row_valid(row_vld), .o_data_valid(dvld), .i_data_ready(ready)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed { logic [31:0] d; logic [3:0] rv; } beat_t;
  beat_t sb[$];
  int n_chk = 0, n_fail = 0;
  int beat_idx = 0, reads = 0, done_cnt = 0;
  logic [31:0] got_d [64];
  logic [3:0]  got_rv [64];
  int          got_reads [64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // SRAM: element e holds e (mod 256); data returns one cycle after the strobe.
  initial forever begin
    @(negedge clk);
    sram_vld = 1'b0;
    sram_dat = '0;
    if (rd_en) begin
      reads++;
      sram_vld = 1'b1;
      for (int j = 0; j < 8; j++) sram_dat[j*8 +: 8] = 8'(int'(rd_addr) * 8 + j);
    end
  end

  // Monitor: pops the scoreboard on every accepted beat.
  initial forever begin
    @(negedge clk);
    if (nrst) begin
      if (done) done_cnt++;
      if (dvld && ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected none", odata);
        end else begin
          beat_t x;
          x = sb.pop_front();
          chk("beat_data", odata, x.d);
          chk("beat_row_valid", 32'(row_vld), 32'(x.rv));
        end
        if (beat_idx < 64) begin
          got_d[beat_idx]     = odata;
          got_rv[beat_idx]    = row_vld;
          got_reads[beat_idx] = reads;
        end
        beat_idx++;
      end
    end
  end

  task automatic push_job(input int isz, input int osz, input int str, input int pd);
    int n, nb;
    n  = osz * osz;
    nb = (n + 3) / 4;
    for (int b = 0; b < nb; b++)
      for (int t = 0; t < 9; t++) begin
        beat_t x;
        x = '0;
        for (int r = 0; r < 4; r++) begin
          int p, iy, ix;
          p = b * 4 + r;
          if (p < n) begin
            x.rv[r] = 1'b1;
            iy = (p / osz) * str + t / 3 - pd;
            ix = (p % osz) * str + t % 3 - pd;
            if (iy >= 0 && iy < isz && ix >= 0 && ix < isz) x.d[r*8 +: 8] = 8'(iy * isz + ix);
          end
        end
        sb.push_back(x);
      end
  endtask

  task automatic pulse_start(input int isz, input int osz, input int str);
    i_size = 8'(isz); o_size = 8'(osz); stride = 8'(str);
    beat_idx = 0;
    reads = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int d0);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(posedge clk);
    if (done_cnt == d0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no o_done expected o_done", nm);
    end
    repeat (3) @(posedge clk);
    chk({nm, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    chk({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic run_job(input string nm, input int isz, input int osz, input int str, input int pd);
    int d0;
    d0 = done_cnt;
    push_job(isz, osz, str, pd);
    pulse_start(isz, osz, str);
    wait_done(nm, d0);
  endtask

  initial begin
    logic [31:0] snap;
    int r0, d0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_dvld", 32'(dvld), 32'd0);
    chk("rst_data", odata, 32'd0);
    chk("rst_row_valid", 32'(row_vld), 32'd0);
    @(posedge clk); #1 nrst = 1'b1;

    run_job("basic", 4, 2, 1, 0);
    chk("basic_beats", 32'(beat_idx), 32'd9);
    chk("basic_tap0", got_d[0], 32'h05040100);
    chk("basic_tap8", got_d[8], 32'h0F0E0B0A);
    chk("basic_tap0_reads", 32'(got_reads[0]), 32'd1);

    run_job("partial", 5, 3, 1, 0);
    chk("partial_beats", 32'(beat_idx), 32'd27);
    chk("partial_rv_b17", 32'(got_rv[17]), 32'hF);
    chk("partial_rv_b18", 32'(got_rv[18]), 32'h1);
    chk("partial_rv_b26", 32'(got_rv[26]), 32'h1);
    chk("partial_b2_tap0", got_d[18], 32'h0000000C);

    run_job("stride", 5, 2, 2, 0);
    chk("stride_tap0", got_d[0], 32'h0C0A0200);
    chk("stride_tap4", got_d[4], 32'h12100806);

    // Backpressure, then synchronous clear mid-job.
    ready = 1'b0;
    push_job(4, 2, 1, 0);
    pulse_start(4, 2, 1);
    for (int i = 0; i < 200 && !dvld; i++) @(negedge clk);
    chk("bp_reach_emit", 32'(dvld), 32'd1);
    snap = odata;
    r0 = reads;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_data_stable", odata, snap);
      chk("bp_no_read", 32'(rd_en), 32'd0);
    end
    chk("bp_read_count", 32'(reads - r0), 32'd0);
    d0 = done_cnt;
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_dvld", 32'(dvld), 32'd0);
    chk("clr_data", odata, 32'd0);
    chk("clr_row_valid", 32'(row_vld), 32'd0);
    repeat (5) @(negedge clk);
    chk("clr_no_done", 32'(done_cnt - d0), 32'd0);
    sb.delete();
    @(posedge clk); #1 ready = 1'b1;
    run_job("after_clr", 4, 2, 1, 0);
    chk("after_clr_beats", 32'(beat_idx), 32'd9);
    chk("after_clr_tap0", got_d[0], 32'h05040100);

`ifdef IM2COL_ROUTER_PAD_EN
    pad = 8'd1;
    run_job("pad", 4, 4, 1, 1);
    chk("pad_tap0", got_d[0], 32'h00000000);
    chk("pad_tap0_rv", 32'(got_rv[0]), 32'hF);
    chk("pad_tap0_reads", 32'(got_reads[0]), 32'd0);
    chk("pad_tap4", got_d[4], 32'h03020100);
    pad = 8'd0;
`endif

    // Zero output size: o_done two cycles after the start pulse, nothing else.
    d0 = done_cnt;
    i_size = 8'd4; o_size = 8'd0; stride = 8'd1;
    beat_idx = 0;
    reads = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("zero_done_c1", 32'(done), 32'd0);
    chk("zero_busy_c1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("zero_done_c2", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    chk("zero_done_count", 32'(done_cnt - d0), 32'd1);
    chk("zero_reads", 32'(reads), 32'd0);
    chk("zero_beats", 32'(beat_idx), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/im2col_router.md
Name: im2col_router

Overview:
- Parametrised successor to the fixed 4-row input router.
- Generates its own output-pixel coordinates and fetches input-feature-map elements from a packed-word SRAM read port.
- Emits one im2col beat per kernel tap: ROW_COUNT parallel lanes, one lane per output pixel, fed to the PE array rows over a valid/ready handshake.
- Adds over the previous generation: partial last batches, a word-reuse (coalescing) register, and optional zero padding.

Parameters:
- ROW_COUNT, 4: output lanes, i.e. output pixels per batch.
- DATA_WIDTH, 8: element width.
- WORD_ELEMS, 8: elements per SRAM word; must be a power of 2. SRAM word width = DATA_WIDTH*WORD_ELEMS.
- ADDR_WIDTH, 8: SRAM address width.
- DIM_WIDTH, 8: width of size, stride and coordinate fields.
- KERNEL_SIZE, 3: square kernel side K.

Ports:
- i_clk, in, 1: clock.
- i_nrst, in, 1: asynchronous active-low reset.
- i_reg_clear, in, 1: synchronous clear.
- i_start, in, 1: start pulse; sampled only in IDLE.
- i_start_addr, in, ADDR_WIDTH: SRAM word address of element 0.
- i_i_size, in, DIM_WIDTH: input side length.
- i_o_size, in, DIM_WIDTH: output side length.
- i_stride, in, DIM_WIDTH: stride, must be ≥1.
- o_busy, out, 1: high when not IDLE.
- o_done, out, 1: one-cycle completion pulse.
- o_sram_read_en, out, 1: read strobe.
- o_sram_read_addr, out, ADDR_WIDTH: read address.
- i_sram_data, in, DATA_WIDTH*WORD_ELEMS: read data; element j at bits [j*DATA_WIDTH +: DATA_WIDTH].
- i_sram_data_valid, in, 1: read-data valid. Latency ≥1 cycle, one read outstanding.
- o_data, out, ROW_COUNT×DATA_WIDTH: lane r at o_data[r].
- o_row_valid, out, ROW_COUNT: per-lane valid mask.
- o_data_valid, out, 1: beat valid.
- i_data_ready, in, 1: consumer ready.

Behaviour:
- Reset (async) and i_reg_clear (sync) both force:
  - state IDLE;
  - all counters to 0 and the word register invalid;
  - every output to 0.
  - i_reg_clear overrides all other inputs and produces no o_done.
- i_start in IDLE:
  - latch the config inputs;
  - invalidate the word register;
  - go to FETCH, or to DONE if i_o_size==0 (no reads).
- i_start outside IDLE is ignored.
- Pixel order and batching:
  - Output pixels are numbered p = oy*o_size+ox in raster order, with N = o_size².
  - Batch b covers p = b*ROW_COUNT+r. Lanes with p ≥ N have o_row_valid[r]=0, data 0 and no read.
- Taps are visited in order t = ky*K+kx, from 0 to K²−1.
- Addressing for lane r at tap t:
  - iy = oy*stride+ky−pad, ix = ox*stride+kx−pad (pad=0 unless the optional feature is enabled).
  - e = iy*i_size+ix, computed in 2*DIM_WIDTH bits.
  - addr = i_start_addr + e/WORD_ELEMS, truncated to ADDR_WIDTH, so it wraps modulo 2^ADDR_WIDTH.
  - lane select = e%WORD_ELEMS.
- States:
  - IDLE: described above.
  - FETCH (one lane per visit, r = 0..ROW_COUNT−1):
    - Invalid lane: capture 0, 1 cycle.
    - Hit (word register valid and addr equals the stored address): capture from the stored word, 1 cycle, no read.
    - Miss: assert o_sram_read_en with o_sram_read_addr for exactly one cycle, then go to WAIT.
    - After the last lane, go to EMIT.
  - WAIT: on i_sram_data_valid, store the word and address, mark the register valid, capture the lane element, then advance the lane (back to FETCH) or go to EMIT.
  - EMIT:
    - o_data_valid=1; o_data and o_row_valid are held stable until i_data_ready.
    - On handshake: next tap → FETCH (lane 0). After the last tap: next batch → FETCH, or DONE after the last batch.
  - DONE: o_done=1 for one cycle, then IDLE.
- o_busy is high in every state except IDLE.
- Beats per job: ceil(N/ROW_COUNT)*K².
- Async reset mid-operation abandons the job. Any outstanding read data that arrives afterwards is ignored, since the block is in IDLE.

Optional Feature:
- Macro: IM2COL_ROUTER_PAD_EN.
- Enabled:
  - adds port i_pad (in, DIM_WIDTH), latched on i_start;
  - lanes with iy or ix outside [0, i_size), evaluated as signed values, capture 0 in 1 cycle with no read; o_row_valid stays 1.
- Disabled: the port is absent, pad is treated as 0, and no bounds check is performed.

Test Plan:
- Common setup: WORD_ELEMS=8, ROW_COUNT=4, K=3, and SRAM element e holds the value e.
- Basic job: i_size=4, o_size=2, stride=1, ready always high → tap0 o_data={0,1,4,5}, tap8 {10,11,14,15}, exactly 9 beats, 1 SRAM read during tap0, o_done once.
- Partial batch: i_size=5, o_size=3, stride=1 → 27 beats; beats 1–18 have o_row_valid=4'b1111; beats 19–27 (batch 2) have o_row_valid=4'b0001, lanes 1–3 = 0; batch 2 tap0 lane0=12.
- Stride: i_size=5, o_size=2, stride=2 → tap0 {0,2,10,12}, tap4 {6,8,16,18}.
- Backpressure/clear: hold i_data_ready low 5 cycles in EMIT → o_data stable and no reads. Then pulse i_reg_clear → next cycle IDLE, outputs 0, no o_done; a new i_start then runs normally.
- Padding (macro on): i_size=4, o_size=4, pad=1 → batch0 tap0 {0,0,0,0} with no reads, tap4 {0,1,2,3}.
- Zero size: i_o_size=0 → o_done 2 cycles after i_start, no reads, no beats.
